// File: rtl/soc_system_sdram_init_seq.sv
// SDR SDRAM power-up sequencer: lock filter, 200us NOP wait, PRECHARGE ALL, n x AUTO REFRESH, LOAD MODE.
// Latency: outputs registered; cke rises 2 (sync) + LOCK_STABLE_CYCLES edges after lock, init_done follows the full sequence.
// Backpressure: none; lock loss aborts to WAIT_LOCK. Optional status ports under `SDRAM_INIT_STATUS_EN`.
module soc_system_sdram_init_seq #(
   parameter int ADDR_W             = 13,
   parameter int LOCK_STABLE_CYCLES = 16,
   parameter int POWERUP_CYCLES     = 24000,
   parameter int TRP_CYCLES         = 3,
   parameter int TRFC_CYCLES        = 8,
   parameter int NUM_REFRESH        = 8,
   parameter int TMRD_CYCLES        = 2,
   parameter logic [ADDR_W-1:0] MODE_REG = ADDR_W'(13'h0230)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pll_locked,
   output logic              cke,
   output logic              cs_n,
   output logic              ras_n,
   output logic              cas_n,
   output logic              we_n,
   output logic [ADDR_W-1:0] addr,
   output logic [1:0]        ba,
   output logic              init_busy,
   output logic              init_done
`ifdef SDRAM_INIT_STATUS_EN
   ,
   output logic [3:0]        init_state,
   output logic [7:0]        lock_loss_cnt
`endif
);

   localparam int MAX_WAIT = (POWERUP_CYCLES > LOCK_STABLE_CYCLES) ? POWERUP_CYCLES : LOCK_STABLE_CYCLES;
   localparam int CNT_W    = $clog2(MAX_WAIT + 1);

   // Counter reload values: a wait state of N cycles loads N-1 and exits when the counter reads 0.
   localparam logic [CNT_W-1:0] PU_LOAD   = CNT_W'((POWERUP_CYCLES > 0) ? POWERUP_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] TRP_LOAD  = CNT_W'((TRP_CYCLES > 0) ? TRP_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] TRFC_LOAD = CNT_W'((TRFC_CYCLES > 0) ? TRFC_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] TMRD_LOAD = CNT_W'((TMRD_CYCLES > 0) ? TMRD_CYCLES - 1 : 0);
   // The WAIT_LOCK cycle that sees lock_s=1 is the first counted stable cycle.
   localparam logic [CNT_W-1:0] LF_LAST   = CNT_W'((LOCK_STABLE_CYCLES > 1) ? LOCK_STABLE_CYCLES - 1 : 1);
   localparam logic [3:0]       REF_TOTAL = 4'(NUM_REFRESH);

   typedef enum logic [3:0] {
      ST_WAIT_LOCK   = 4'd0,
      ST_LOCK_FILTER = 4'd1,
      ST_POWERUP     = 4'd2,
      ST_PRECHARGE   = 4'd3,
      ST_WAIT_TRP    = 4'd4,
      ST_REFRESH     = 4'd5,
      ST_WAIT_TRFC   = 4'd6,
      ST_LMR         = 4'd7,
      ST_WAIT_TMRD   = 4'd8,
      ST_DONE        = 4'd9
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [3:0]        r_ref_cnt, w_ref_nxt;
   logic              r_lock_meta, r_lock_s;
   logic              w_in_seq;

   logic              r_cke, r_cs_n, r_ras_n, r_cas_n, r_we_n, r_busy, r_done;
   logic [ADDR_W-1:0] r_addr;
   logic              w_cke_nxt, w_cs_n_nxt, w_ras_n_nxt, w_cas_n_nxt, w_we_n_nxt, w_busy_nxt, w_done_nxt;
   logic [ADDR_W-1:0] w_addr_nxt;

   // Past the lock filter: any lock drop from here aborts the whole sequence.
   assign w_in_seq = (r_state != ST_WAIT_LOCK) && (r_state != ST_LOCK_FILTER);

   // Two-flop synchroniser for the asynchronous PLL lock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lock_meta <= 1'b0;
         r_lock_s    <= 1'b0;
      end else begin
         r_lock_meta <= pll_locked;
         r_lock_s    <= r_lock_meta;
      end
   end

   // State, shared wait counter and refresh counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_WAIT_LOCK;
         r_cnt     <= '0;
         r_ref_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_ref_cnt <= w_ref_nxt;
      end
   end

   // Next state, counter reloads and the registered-output decode of the next state.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ref_nxt   = r_ref_cnt;

      case (r_state)
         ST_WAIT_LOCK: begin
            w_cnt_nxt = '0;
            w_ref_nxt = '0;
            if (r_lock_s) begin
               if (LOCK_STABLE_CYCLES <= 1) begin
                  w_state_nxt = ST_POWERUP;
                  w_cnt_nxt   = PU_LOAD;
               end else begin
                  w_state_nxt = ST_LOCK_FILTER;
                  w_cnt_nxt   = CNT_W'(1);
               end
            end
         end
         ST_LOCK_FILTER: begin
            if (!r_lock_s) begin
               w_state_nxt = ST_WAIT_LOCK;
               w_cnt_nxt   = '0;
            end else if (r_cnt >= LF_LAST) begin
               w_state_nxt = ST_POWERUP;
               w_cnt_nxt   = PU_LOAD;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_POWERUP: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_PRECHARGE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         ST_PRECHARGE: begin
            w_cnt_nxt = TRP_LOAD;
            w_state_nxt = (TRP_CYCLES == 0) ? ST_REFRESH : ST_WAIT_TRP;
         end
         ST_WAIT_TRP: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_REFRESH;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         ST_REFRESH: begin
            w_ref_nxt = r_ref_cnt + 4'd1;
            w_cnt_nxt = TRFC_LOAD;
            if (TRFC_CYCLES != 0) begin
               w_state_nxt = ST_WAIT_TRFC;
            end else if ((r_ref_cnt + 4'd1) < REF_TOTAL) begin
               w_state_nxt = ST_REFRESH;
            end else begin
               w_state_nxt = ST_LMR;
            end
         end
         ST_WAIT_TRFC: begin
            if (r_cnt == '0) begin
               w_state_nxt = (r_ref_cnt < REF_TOTAL) ? ST_REFRESH : ST_LMR;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         ST_LMR: begin
            w_cnt_nxt   = TMRD_LOAD;
            w_state_nxt = (TMRD_CYCLES == 0) ? ST_DONE : ST_WAIT_TMRD;
         end
         ST_WAIT_TMRD: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         ST_DONE: begin
            w_cnt_nxt = '0;
         end
         default: begin
            w_state_nxt = ST_WAIT_LOCK;
            w_cnt_nxt   = '0;
            w_ref_nxt   = '0;
         end
      endcase

      // Lock loss overrides everything: abandon any command and restart from scratch.
      if (w_in_seq && !r_lock_s) begin
         w_state_nxt = ST_WAIT_LOCK;
         w_cnt_nxt   = '0;
         w_ref_nxt   = '0;
      end

      // Output decode: INHIBIT before the filter completes, otherwise NOP unless a command state.
      w_cke_nxt   = 1'b1;
      w_cs_n_nxt  = 1'b0;
      w_ras_n_nxt = 1'b1;
      w_cas_n_nxt = 1'b1;
      w_we_n_nxt  = 1'b1;
      w_addr_nxt  = '0;
      w_busy_nxt  = 1'b1;
      w_done_nxt  = 1'b0;
      case (w_state_nxt)
         ST_WAIT_LOCK: begin
            w_cke_nxt  = 1'b0;
            w_cs_n_nxt = 1'b1;
            w_busy_nxt = 1'b0;
         end
         ST_LOCK_FILTER: begin
            w_cke_nxt  = 1'b0;
            w_cs_n_nxt = 1'b1;
         end
         ST_PRECHARGE: begin
            w_ras_n_nxt    = 1'b0;
            w_we_n_nxt     = 1'b0;
            w_addr_nxt[10] = 1'b1;
         end
         ST_REFRESH: begin
            w_ras_n_nxt = 1'b0;
            w_cas_n_nxt = 1'b0;
         end
         ST_LMR: begin
            w_ras_n_nxt = 1'b0;
            w_cas_n_nxt = 1'b0;
            w_we_n_nxt  = 1'b0;
            w_addr_nxt  = MODE_REG;
         end
         ST_DONE: begin
            w_busy_nxt = 1'b0;
            w_done_nxt = 1'b1;
         end
         default: begin
            w_cke_nxt = 1'b1;
         end
      endcase
   end

   // Registered SDRAM command bus and handshake flags; reset value is INHIBIT with cke low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cke   <= 1'b0;
         r_cs_n  <= 1'b1;
         r_ras_n <= 1'b1;
         r_cas_n <= 1'b1;
         r_we_n  <= 1'b1;
         r_addr  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_cke   <= w_cke_nxt;
         r_cs_n  <= w_cs_n_nxt;
         r_ras_n <= w_ras_n_nxt;
         r_cas_n <= w_cas_n_nxt;
         r_we_n  <= w_we_n_nxt;
         r_addr  <= w_addr_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign cke       = r_cke;
   assign cs_n      = r_cs_n;
   assign ras_n     = r_ras_n;
   assign cas_n     = r_cas_n;
   assign we_n      = r_we_n;
   assign addr      = r_addr;
   assign ba        = 2'b00;
   assign init_busy = r_busy;
   assign init_done = r_done;

`ifdef SDRAM_INIT_STATUS_EN
   logic       w_lock_lost;
   logic [7:0] r_loss_cnt;

   assign w_lock_lost = w_in_seq && !r_lock_s;

   // Saturating count of restarts caused by lock loss after the filter; only rst clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_loss_cnt <= 8'd0;
      end else if (w_lock_lost && (r_loss_cnt != 8'hFF)) begin
         r_loss_cnt <= r_loss_cnt + 8'd1;
      end
   end

   assign init_state    = r_state;
   assign lock_loss_cnt = r_loss_cnt;
`endif

endmodule

// File: tb/tb_soc_system_sdram_init_seq.sv
// Bench for soc_system_sdram_init_seq: directed tables of {lock input, expected outputs} per cycle.
// Latency: checks sampled on the falling edge after each rising edge.
// Backpressure: not applicable; a second instance covers zero TRP/TMRD.
module tb_soc_system_sdram_init_seq;

   localparam logic [3:0] C_INH = 4'b1111;
   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_REF = 4'b0001;
   localparam logic [3:0] C_LMR = 4'b0000;

   typedef struct {
      int          k;
      logic        lk;
      logic [21:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst, pll_locked, z_locked;
   logic cke, cs_n, ras_n, cas_n, we_n, init_busy, init_done;
   logic [12:0] addr;
   logic [1:0]  ba;
   logic z_cke, z_cs_n, z_ras_n, z_cas_n, z_we_n, z_busy, z_done;
   logic [12:0] z_addr;
   logic [1:0]  z_ba;
`ifdef SDRAM_INIT_STATUS_EN
   logic [3:0] init_state, z_state;
   logic [7:0] lock_loss_cnt, z_loss;
`endif

   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_pre, n_ref, n_lmr;
   int   norm_lo, norm_hi, gl_lo, gl_hi;
   vec_t tbl[$];

   always #5 clk = ~clk;

   soc_system_sdram_init_seq #(
      .ADDR_W(13), .LOCK_STABLE_CYCLES(4), .POWERUP_CYCLES(20), .TRP_CYCLES(3),
      .TRFC_CYCLES(8), .NUM_REFRESH(2), .TMRD_CYCLES(2), .MODE_REG(13'h0230)
   ) dut (
      .clk(clk), .rst(rst), .pll_locked(pll_locked), .cke(cke), .cs_n(cs_n),
      .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .addr(addr), .ba(ba),
      .init_busy(init_busy), .init_done(init_done)
`ifdef SDRAM_INIT_STATUS_EN
      , .init_state(init_state), .lock_loss_cnt(lock_loss_cnt)
`endif
   );

   soc_system_sdram_init_seq #(
      .ADDR_W(13), .LOCK_STABLE_CYCLES(4), .POWERUP_CYCLES(20), .TRP_CYCLES(0),
      .TRFC_CYCLES(8), .NUM_REFRESH(2), .TMRD_CYCLES(0), .MODE_REG(13'h0230)
   ) dut_z (
      .clk(clk), .rst(rst), .pll_locked(z_locked), .cke(z_cke), .cs_n(z_cs_n),
      .ras_n(z_ras_n), .cas_n(z_cas_n), .we_n(z_we_n), .addr(z_addr), .ba(z_ba),
      .init_busy(z_busy), .init_done(z_done)
`ifdef SDRAM_INIT_STATUS_EN
      , .init_state(z_state), .lock_loss_cnt(z_loss)
`endif
   );

   function automatic logic [21:0] pk(logic ck, logic [3:0] cmd, logic [12:0] ad, logic bz, logic dn);
      return {ck, cmd, bz, dn, ad, 2'b00};
   endfunction

   function automatic logic [21:0] obs();
      return {cke, cs_n, ras_n, cas_n, we_n, init_busy, init_done, addr, ba};
   endfunction

   function automatic logic [21:0] zobs();
      return {z_cke, z_cs_n, z_ras_n, z_cas_n, z_we_n, z_busy, z_done, z_addr, z_ba};
   endfunction

   function automatic void add(int k, logic lk, logic ck, logic [3:0] cmd, logic [12:0] ad, logic bz, logic dn);
      vec_t v;
      v.k   = k;
      v.lk  = lk;
      v.exp = pk(ck, cmd, ad, bz, dn);
      tbl.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic count_cmd();
      case ({cs_n, ras_n, cas_n, we_n})
         C_PRE:   n_pre++;
         C_REF:   n_ref++;
         C_LMR:   n_lmr++;
         default: ;
      endcase
   endtask

   // Entry i: drive its lock level, advance to its cycle index, compare all outputs.
   task automatic run_tbl(input int lo, input int hi, input string tag);
      int c = 0;
      n_pre = 0;
      n_ref = 0;
      n_lmr = 0;
      for (int i = lo; i < hi; i++) begin
         pll_locked = tbl[i].lk;
         while (c < tbl[i].k) begin
            step();
            c++;
            count_cmd();
         end
         chk($sformatf("%s@%0d", tag, tbl[i].k), 32'(obs()), 32'(tbl[i].exp));
      end
   endtask

   initial begin
      // Full sequence with lock held high: cke at edge 6, done 45 edges later.
      norm_lo = tbl.size();
      add(1,  1'b1, 1'b0, C_INH, 13'h0,    1'b0, 1'b0);
      add(2,  1'b1, 1'b0, C_INH, 13'h0,    1'b0, 1'b0);
      add(3,  1'b1, 1'b0, C_INH, 13'h0,    1'b1, 1'b0);
      add(5,  1'b1, 1'b0, C_INH, 13'h0,    1'b1, 1'b0);
      add(6,  1'b1, 1'b1, C_NOP, 13'h0,    1'b1, 1'b0);
      add(25, 1'b1, 1'b1, C_NOP, 13'h0,    1'b1, 1'b0);
      add(26, 1'b1, 1'b1, C_PRE, 13'h0400, 1'b1, 1'b0);
      add(27, 1'b1, 1'b1, C_NOP, 13'h0,    1'b1, 1'b0);
      add(29, 1'b1, 1'b1, C_NOP, 13'h0,    1'b1, 1'b0);
      add(30, 1'b1, 1'b1, C_REF, 13'h0,    1'b1, 1'b0);
      add(31, 1'b1, 1'b1, C_NOP, 13'h0,    1'b1, 1'b0);
      add(38, 1'b1, 1'b1, C_NOP, 13'h0,    1'b1, 1'b0);
      add(39, 1'b1, 1'b1, C_REF, 13'h0,    1'b1, 1'b0);
      add(40, 1'b1, 1'b1, C_NOP, 13'h0,    1'b1, 1'b0);
      add(47, 1'b1, 1'b1, C_NOP, 13'h0,    1'b1, 1'b0);
      add(48, 1'b1, 1'b1, C_LMR, 13'h0230, 1'b1, 1'b0);
      add(49, 1'b1, 1'b1, C_NOP, 13'h0,    1'b1, 1'b0);
      add(50, 1'b1, 1'b1, C_NOP, 13'h0,    1'b1, 1'b0);
      add(51, 1'b1, 1'b1, C_NOP, 13'h0,    1'b0, 1'b1);
      add(56, 1'b1, 1'b1, C_NOP, 13'h0,    1'b0, 1'b1);
      norm_hi = tbl.size();

      // Lock high 3 cycles, low 1, then high: filter restarts, cke waits for 4 fresh locked cycles.
      gl_lo = tbl.size();
      add(1,  1'b1, 1'b0, C_INH, 13'h0, 1'b0, 1'b0);
      add(2,  1'b1, 1'b0, C_INH, 13'h0, 1'b0, 1'b0);
      add(3,  1'b1, 1'b0, C_INH, 13'h0, 1'b1, 1'b0);
      add(4,  1'b0, 1'b0, C_INH, 13'h0, 1'b1, 1'b0);
      add(5,  1'b1, 1'b0, C_INH, 13'h0, 1'b1, 1'b0);
      add(6,  1'b1, 1'b0, C_INH, 13'h0, 1'b0, 1'b0);
      add(7,  1'b1, 1'b0, C_INH, 13'h0, 1'b1, 1'b0);
      add(8,  1'b1, 1'b0, C_INH, 13'h0, 1'b1, 1'b0);
      add(9,  1'b1, 1'b0, C_INH, 13'h0, 1'b1, 1'b0);
      add(10, 1'b1, 1'b1, C_NOP, 13'h0, 1'b1, 1'b0);
      add(11, 1'b1, 1'b1, C_NOP, 13'h0, 1'b1, 1'b0);
      gl_hi = tbl.size();

      // Reset state.
      rst = 1'b1;
      pll_locked = 1'b0;
      z_locked = 1'b0;
      repeat (3) step();
      chk("reset_main", 32'(obs()), 32'(pk(1'b0, C_INH, 13'h0, 1'b0, 1'b0)));
      chk("reset_zero", 32'(zobs()), 32'(pk(1'b0, C_INH, 13'h0, 1'b0, 1'b0)));
      rst = 1'b0;
      repeat (2) step();
      chk("idle_unlocked", 32'(obs()), 32'(pk(1'b0, C_INH, 13'h0, 1'b0, 1'b0)));

      // Zero TRP/TMRD: REFRESH right after PRECHARGE, done right after LMR.
      z_locked = 1'b1;
      for (int k = 1; k <= 48; k++) begin
         step();
         case (k)
            25: chk("zero@25", 32'(zobs()), 32'(pk(1'b1, C_NOP, 13'h0,    1'b1, 1'b0)));
            26: chk("zero@26", 32'(zobs()), 32'(pk(1'b1, C_PRE, 13'h0400, 1'b1, 1'b0)));
            27: chk("zero@27", 32'(zobs()), 32'(pk(1'b1, C_REF, 13'h0,    1'b1, 1'b0)));
            28: chk("zero@28", 32'(zobs()), 32'(pk(1'b1, C_NOP, 13'h0,    1'b1, 1'b0)));
            36: chk("zero@36", 32'(zobs()), 32'(pk(1'b1, C_REF, 13'h0,    1'b1, 1'b0)));
            45: chk("zero@45", 32'(zobs()), 32'(pk(1'b1, C_LMR, 13'h0230, 1'b1, 1'b0)));
            46: chk("zero@46", 32'(zobs()), 32'(pk(1'b1, C_NOP, 13'h0,    1'b0, 1'b1)));
            default: ;
         endcase
      end

      // Lock glitch on the main instance.
      run_tbl(gl_lo, gl_hi, "glitch");

      // Asynchronous reset while in POWERUP with cke high.
      rst = 1'b1;
      #1;
      chk("async_rst_pu", 32'(obs()), 32'(pk(1'b0, C_INH, 13'h0, 1'b0, 1'b0)));
      pll_locked = 1'b0;
      step();
      rst = 1'b0;

      // Normal sequence.
      run_tbl(norm_lo, norm_hi, "normal");
      chk("normal_n_pre", n_pre, 1);
      chk("normal_n_ref", n_ref, 2);
      chk("normal_n_lmr", n_lmr, 1);

      // Lock loss after done: two sync edges then back to WAIT_LOCK.
      pll_locked = 1'b0;
      repeat (2) step();
      chk("loss_edge2", 32'(obs()), 32'(pk(1'b1, C_NOP, 13'h0, 1'b0, 1'b1)));
      step();
      chk("loss_edge3", 32'(obs()), 32'(pk(1'b0, C_INH, 13'h0, 1'b0, 1'b0)));
      run_tbl(norm_lo, norm_hi, "relock");
      chk("relock_n_ref", n_ref, 2);
`ifdef SDRAM_INIT_STATUS_EN
      chk("loss_cnt_1", 32'(lock_loss_cnt), 32'd1);
      chk("state_done", 32'(init_state), 32'd9);
`endif

      // Reset in the second WAIT_TRFC, then full rerun.
      pll_locked = 1'b0;
      repeat (3) step();
      pll_locked = 1'b1;
      repeat (42) step();
      chk("in_trfc2", 32'(obs()), 32'(pk(1'b1, C_NOP, 13'h0, 1'b1, 1'b0)));
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_trfc", 32'(obs()), 32'(pk(1'b0, C_INH, 13'h0, 1'b0, 1'b0)));
`ifdef SDRAM_INIT_STATUS_EN
      chk("loss_cnt_rst", 32'(lock_loss_cnt), 32'd0);
`endif
      step();
      rst = 1'b0;
      run_tbl(norm_lo, norm_hi, "after_rst");
      chk("after_rst_n_pre", n_pre, 1);

`ifdef SDRAM_INIT_STATUS_EN
      // 260 lock-loss restarts from POWERUP/DONE saturate at 255.
      for (int i = 0; i < 260; i++) begin
         pll_locked = 1'b0;
         repeat (3) step();
         pll_locked = 1'b1;
         repeat (7) step();
      end
      chk("loss_cnt_sat", 32'(lock_loss_cnt), 32'd255);
      chk("state_powerup", 32'(init_state), 32'd2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
